// File: rtl/axi_master_bridge_pkg.sv
// Shared state encoding and AXI constants for the single-outstanding AXI master bridge.
// Width macros fall back to a 32-bit data/address profile when the AXI define header is absent.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

package axi_master_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_master_bridge_if.sv
// AXI4 AR/R/AW/W/B signal bundle between the master bridge and the interconnect.
// Handshake: a transfer happens on a rising clock edge where VALID and READY are both high;
// VALID never waits on READY, and VALID plus its payload stay stable until that edge.
interface axi_master_bridge_if;

    logic [`AXI_ID_BITS-1:0]   ARID_M;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_M;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_M;
    logic [2:0]                ARSIZE_M;
    logic [1:0]                ARBURST_M;
    logic                      ARVALID_M;
    logic                      ARREADY_M;

    logic [`AXI_ID_BITS-1:0]   RID_M;
    logic [`AXI_DATA_BITS-1:0] RDATA_M;
    logic [1:0]                RRESP_M;
    logic                      RLAST_M;
    logic                      RVALID_M;
    logic                      RREADY_M;

    logic [`AXI_ID_BITS-1:0]   AWID_M;
    logic [`AXI_ADDR_BITS-1:0] AWADDR_M;
    logic [`AXI_LEN_BITS-1:0]  AWLEN_M;
    logic [2:0]                AWSIZE_M;
    logic [1:0]                AWBURST_M;
    logic                      AWVALID_M;
    logic                      AWREADY_M;

    logic [`AXI_DATA_BITS-1:0] WDATA_M;
    logic [`AXI_STRB_BITS-1:0] WSTRB_M;
    logic                      WLAST_M;
    logic                      WVALID_M;
    logic                      WREADY_M;

    logic [`AXI_ID_BITS-1:0]   BID_M;
    logic [1:0]                BRESP_M;
    logic                      BVALID_M;
    logic                      BREADY_M;

    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        input  ARREADY_M,
        input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output RREADY_M,
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M
    );

    modport slave (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        output ARREADY_M,
        output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        input  RREADY_M,
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M
    );

endinterface

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master turning CPU read/write requests (1-4 beat INCR) into AXI bursts.
// Define AXI_MASTER_RESP_CHECK_EN to report RRESP/BRESP errors and short/long read bursts on cpu_err.
module axi_master_bridge
    import axi_master_bridge_pkg::*;
#(
    parameter int unsigned MASTER_ID = 0,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [`AXI_ADDR_BITS-1:0] cpu_addr,
    input  logic [`AXI_LEN_BITS-1:0]  cpu_len,
    input  logic [`AXI_DATA_BITS-1:0] cpu_wdata,
    input  logic [`AXI_STRB_BITS-1:0] cpu_wstrb,
    output logic                      cpu_wnext,
    output logic [`AXI_DATA_BITS-1:0] cpu_rdata,
    output logic                      cpu_rvalid,
    output logic                      cpu_busy,
    output logic                      cpu_done,
    output logic                      cpu_err,
    axi_master_bridge_if.master       axi,
    output state_t                    dbg_state
);

    localparam int LEN_W = `AXI_LEN_BITS;
    localparam int ID_W  = `AXI_ID_BITS;
    localparam logic [ID_W-1:0] ID_VAL   = ID_W'(MASTER_ID);
    localparam logic [2:0]      BEAT_MAX = 3'(MAX_BURST);

    state_t                    state, state_nxt;
    logic [`AXI_ADDR_BITS-1:0] addr_q;
    logic [LEN_W-1:0]          len_q;
    logic [2:0]                beat_cnt;
    logic                      err_q;
    logic                      oversize, w_last, r_hs, w_hs, b_hs;

    assign oversize = 32'(cpu_len) >= MAX_BURST;
    assign w_last   = (LEN_W'(beat_cnt) == len_q);
    assign r_hs     = (state == ST_R) && axi.RVALID_M;
    assign w_hs     = (state == ST_W) && axi.WREADY_M;
    assign b_hs     = (state == ST_B) && axi.BVALID_M;

    assign dbg_state = state;
    assign cpu_busy  = (state != ST_IDLE);
    assign cpu_done  = (state == ST_DONE);
    assign cpu_err   = (state == ST_DONE) && err_q;

    always_comb begin
        state_nxt     = state;
        axi.ARID_M    = '0;
        axi.ARADDR_M  = '0;
        axi.ARLEN_M   = '0;
        axi.ARSIZE_M  = '0;
        axi.ARBURST_M = '0;
        axi.ARVALID_M = 1'b0;
        axi.RREADY_M  = 1'b0;
        axi.AWID_M    = '0;
        axi.AWADDR_M  = '0;
        axi.AWLEN_M   = '0;
        axi.AWSIZE_M  = '0;
        axi.AWBURST_M = '0;
        axi.AWVALID_M = 1'b0;
        axi.WDATA_M   = '0;
        axi.WSTRB_M   = '0;
        axi.WLAST_M   = 1'b0;
        axi.WVALID_M  = 1'b0;
        axi.BREADY_M  = 1'b0;
        cpu_wnext     = 1'b0;
        case (state)
            ST_IDLE: if (cpu_req) state_nxt = oversize ? ST_DONE : (cpu_we ? ST_AW : ST_AR);
            ST_AR: begin
                axi.ARID_M    = ID_VAL;
                axi.ARADDR_M  = addr_q;
                axi.ARLEN_M   = len_q;
                axi.ARSIZE_M  = SIZE_WORD;
                axi.ARBURST_M = BURST_INCR;
                axi.ARVALID_M = 1'b1;
                if (axi.ARREADY_M) state_nxt = ST_R;
            end
            ST_R: begin
                axi.RREADY_M = 1'b1;
                if (axi.RVALID_M && axi.RLAST_M) state_nxt = ST_DONE;
            end
            ST_AW: begin
                axi.AWID_M    = ID_VAL;
                axi.AWADDR_M  = addr_q;
                axi.AWLEN_M   = len_q;
                axi.AWSIZE_M  = SIZE_WORD;
                axi.AWBURST_M = BURST_INCR;
                axi.AWVALID_M = 1'b1;
                if (axi.AWREADY_M) state_nxt = ST_W;
            end
            ST_W: begin
                // Write data is not buffered: the CPU holds the beat until cpu_wnext.
                axi.WVALID_M = 1'b1;
                axi.WDATA_M  = cpu_wdata;
                axi.WSTRB_M  = cpu_wstrb;
                axi.WLAST_M  = w_last;
                cpu_wnext    = axi.WREADY_M;
                if (axi.WREADY_M && w_last) state_nxt = ST_B;
            end
            ST_B: begin
                axi.BREADY_M = 1'b1;
                if (axi.BVALID_M) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_rvalid <= r_hs;
            if (r_hs) cpu_rdata <= axi.RDATA_M;
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    err_q    <= cpu_req && oversize;
                    if (cpu_req && !oversize) begin
                        addr_q <= cpu_addr;
                        len_q  <= cpu_len;
                    end
                end
                ST_R: if (r_hs) begin
                    if (beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + 3'd1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                    // beat_cnt still counts the beats before this one, so RLAST expects it to equal len.
                    if ((axi.RRESP_M != RESP_OKAY) || (axi.RLAST_M && (LEN_W'(beat_cnt) != len_q)))
                        err_q <= 1'b1;
`endif
                end
                ST_W: if (w_hs && (beat_cnt != BEAT_MAX)) beat_cnt <= beat_cnt + 3'd1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                ST_B: if (b_hs && (axi.BRESP_M != RESP_OKAY)) err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

`ifndef AXI_MASTER_RESP_CHECK_EN
    logic unused_resp;
    assign unused_resp = ^{axi.RRESP_M, axi.BRESP_M, b_hs};
`endif
    logic unused_ids;
    assign unused_ids = ^{axi.RID_M, axi.BID_M};

endmodule

// File: tb/tb_axi_master_bridge.sv
// Randomized scoreboard bench for axi_master_bridge with a reactive AXI slave model.
// Expected cpu_err follows AXI_MASTER_RESP_CHECK_EN when defined for the build.
module tb_axi_master_bridge;
    import axi_master_bridge_pkg::*;

    logic                      ACLK = 1'b0;
    logic                      ARESET;
    logic                      cpu_req, cpu_we;
    logic [`AXI_ADDR_BITS-1:0] cpu_addr;
    logic [`AXI_LEN_BITS-1:0]  cpu_len;
    logic [`AXI_DATA_BITS-1:0] cpu_wdata;
    logic [`AXI_STRB_BITS-1:0] cpu_wstrb;
    logic                      cpu_wnext, cpu_rvalid, cpu_busy, cpu_done, cpu_err;
    logic [`AXI_DATA_BITS-1:0] cpu_rdata;
    state_t                    dbg_state;

    axi_master_bridge_if bus();

    axi_master_bridge #(.MASTER_ID(0), .MAX_BURST(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_wnext(cpu_wnext),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_busy(cpu_busy),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .axi(bus.master), .dbg_state(dbg_state)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard queues: {addr,len}, {data,strb,last}, read data, done error flag.
    logic [39:0] exp_ar[$];
    logic [39:0] exp_aw[$];
    logic [36:0] exp_w[$];
    logic [31:0] exp_rd[$];
    logic [0:0]  exp_done[$];
    // Slave read plan: {data, resp, last}.
    logic [34:0] rd_plan[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          ar_delay, aw_delay, w_ready_pct, w_stall_beat, r_pct;
    bit          r_toggle;
    logic [1:0]  b_resp_plan;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- AXI slave model ----------------
    initial begin : ar_slave
        int cnt;
        cnt = 0;
        bus.ARREADY_M = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            if (ARESET || !bus.ARVALID_M) begin
                cnt = 0;
                bus.ARREADY_M = 1'b0;
            end else begin
                bus.ARREADY_M = (cnt >= ar_delay);
                cnt++;
            end
        end
    end

    initial begin : aw_slave
        int cnt;
        cnt = 0;
        bus.AWREADY_M = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            if (ARESET || !bus.AWVALID_M) begin
                cnt = 0;
                bus.AWREADY_M = 1'b0;
            end else begin
                bus.AWREADY_M = (cnt >= aw_delay);
                cnt++;
            end
        end
    end

    initial begin : r_slave
        bit          ar_hs, r_hs, go, phase;
        logic [34:0] b;
        go = 0;
        phase = 0;
        bus.RVALID_M = 1'b0;
        bus.RDATA_M  = '0;
        bus.RRESP_M  = '0;
        bus.RLAST_M  = 1'b0;
        bus.RID_M    = '0;
        forever begin
            @(negedge ACLK);
            ar_hs = bus.ARVALID_M && bus.ARREADY_M;
            r_hs  = bus.RVALID_M && bus.RREADY_M;
            @(posedge ACLK); #1;
            if (ARESET) begin
                bus.RVALID_M = 1'b0;
                go = 0;
                rd_plan.delete();
                continue;
            end
            if (ar_hs) go = 1;
            if (r_hs) begin
                b = rd_plan.pop_front();
                if (b[0]) go = 0;
                bus.RVALID_M = 1'b0;
            end
            phase = !phase;
            if (!bus.RVALID_M && go && rd_plan.size() != 0) begin
                if (r_toggle ? phase : ($urandom_range(0, 99) < r_pct)) begin
                    b = rd_plan[0];
                    bus.RVALID_M = 1'b1;
                    bus.RDATA_M  = b[34:3];
                    bus.RRESP_M  = b[2:1];
                    bus.RLAST_M  = b[0];
                end
            end
        end
    end

    initial begin : w_slave
        int beat, stall;
        bit hs, last;
        beat = 0;
        stall = 0;
        bus.WREADY_M = 1'b0;
        forever begin
            @(negedge ACLK);
            hs   = bus.WVALID_M && bus.WREADY_M;
            last = bus.WLAST_M;
            @(posedge ACLK); #1;
            if (ARESET) begin
                beat = 0;
                stall = 0;
                bus.WREADY_M = 1'b0;
                continue;
            end
            if (hs) begin
                beat = last ? 0 : beat + 1;
                if (last) stall = 0;
            end
            if (!bus.WVALID_M) bus.WREADY_M = 1'b0;
            else if (beat == w_stall_beat && stall < 3) begin
                bus.WREADY_M = 1'b0;
                stall++;
            end else bus.WREADY_M = ($urandom_range(0, 99) < w_ready_pct);
        end
    end

    initial begin : b_slave
        bit wl_hs, b_hs, pend;
        int wait_c;
        pend = 0;
        wait_c = 0;
        bus.BVALID_M = 1'b0;
        bus.BRESP_M  = '0;
        bus.BID_M    = '0;
        forever begin
            @(negedge ACLK);
            wl_hs = bus.WVALID_M && bus.WREADY_M && bus.WLAST_M;
            b_hs  = bus.BVALID_M && bus.BREADY_M;
            @(posedge ACLK); #1;
            if (ARESET) begin
                bus.BVALID_M = 1'b0;
                pend = 0;
                continue;
            end
            if (b_hs) bus.BVALID_M = 1'b0;
            if (wl_hs) begin
                pend = 1;
                wait_c = $urandom_range(0, 2);
            end
            if (pend && !bus.BVALID_M) begin
                if (wait_c == 0) begin
                    bus.BVALID_M = 1'b1;
                    bus.BRESP_M  = b_resp_plan;
                    pend = 0;
                end else wait_c--;
            end
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    initial begin : monitor
        bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, aw_done;
        logic [39:0] p_ar, p_aw, e40;
        logic [36:0] p_w, e37;
        logic [31:0] e32;
        logic [0:0]  e1;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; aw_done = 0;
        p_ar = '0; p_aw = '0; p_w = '0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                p_arv = 0; p_awv = 0; p_wv = 0; aw_done = 0;
                continue;
            end
            if (p_arv && !p_arr)
                check(bus.ARVALID_M && {bus.ARADDR_M, bus.ARLEN_M} == p_ar, "ar_hold",
                      {bus.ARVALID_M, bus.ARADDR_M, bus.ARLEN_M}, {1'b1, p_ar});
            if (p_awv && !p_awr)
                check(bus.AWVALID_M && {bus.AWADDR_M, bus.AWLEN_M} == p_aw, "aw_hold",
                      {bus.AWVALID_M, bus.AWADDR_M, bus.AWLEN_M}, {1'b1, p_aw});
            if (p_wv && !p_wr)
                check(bus.WVALID_M && {bus.WDATA_M, bus.WSTRB_M, bus.WLAST_M} == p_w, "w_hold",
                      {bus.WVALID_M, bus.WDATA_M, bus.WSTRB_M, bus.WLAST_M}, {1'b1, p_w});
            if (bus.WVALID_M) check(aw_done, "w_before_aw", 0, 1);

            if (bus.ARVALID_M && bus.ARREADY_M) begin
                check(exp_ar.size() != 0, "ar_unexpected", {bus.ARADDR_M, bus.ARLEN_M}, 0);
                if (exp_ar.size() != 0) begin
                    e40 = exp_ar.pop_front();
                    check({bus.ARADDR_M, bus.ARLEN_M, bus.ARSIZE_M, bus.ARBURST_M, bus.ARID_M}
                          == {e40, 3'b010, 2'b01, 4'd0}, "ar_fields",
                          {bus.ARADDR_M, bus.ARLEN_M, bus.ARSIZE_M, bus.ARBURST_M},
                          {e40, 3'b010, 2'b01});
                end
            end
            if (bus.AWVALID_M && bus.AWREADY_M) begin
                aw_done = 1;
                check(exp_aw.size() != 0, "aw_unexpected", {bus.AWADDR_M, bus.AWLEN_M}, 0);
                if (exp_aw.size() != 0) begin
                    e40 = exp_aw.pop_front();
                    check({bus.AWADDR_M, bus.AWLEN_M, bus.AWSIZE_M, bus.AWBURST_M, bus.AWID_M}
                          == {e40, 3'b010, 2'b01, 4'd0}, "aw_fields",
                          {bus.AWADDR_M, bus.AWLEN_M, bus.AWSIZE_M, bus.AWBURST_M},
                          {e40, 3'b010, 2'b01});
                end
            end
            if (bus.WVALID_M && bus.WREADY_M) begin
                check(exp_w.size() != 0, "w_unexpected", bus.WDATA_M, 0);
                if (exp_w.size() != 0) begin
                    e37 = exp_w.pop_front();
                    check({bus.WDATA_M, bus.WSTRB_M, bus.WLAST_M} == e37, "w_beat",
                          {bus.WDATA_M, bus.WSTRB_M, bus.WLAST_M}, e37);
                end
                if (bus.WLAST_M) aw_done = 0;
            end
            if (cpu_rvalid) begin
                check(exp_rd.size() != 0, "rd_unexpected", cpu_rdata, 0);
                if (exp_rd.size() != 0) begin
                    e32 = exp_rd.pop_front();
                    check(cpu_rdata == e32, "rd_data", cpu_rdata, e32);
                end
            end
            if (cpu_done) begin
                check(exp_done.size() != 0, "done_unexpected", cpu_err, 0);
                if (exp_done.size() != 0) begin
                    e1 = exp_done.pop_front();
                    check(cpu_err == e1, "done_err", cpu_err, e1);
                end
            end
            p_arv = bus.ARVALID_M; p_arr = bus.ARREADY_M; p_ar = {bus.ARADDR_M, bus.ARLEN_M};
            p_awv = bus.AWVALID_M; p_awr = bus.AWREADY_M; p_aw = {bus.AWADDR_M, bus.AWLEN_M};
            p_wv  = bus.WVALID_M;  p_wr  = bus.WREADY_M;
            p_w   = {bus.WDATA_M, bus.WSTRB_M, bus.WLAST_M};
        end
    end

    // ---------------- CPU driver ----------------
    // Called at posedge+1 with the bridge idle; returns at posedge+1 one cycle after cpu_done.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input int resp_err_pct, input logic [1:0] bresp);
        logic [31:0] wd[4];
        logic [3:0]  wsb[4];
        logic [31:0] d;
        logic [1:0]  rr;
        bit          exp_err, wn, dn;
        int          idx, wn_cnt;
        exp_err = 0;
        if (len >= 8'd4) exp_err = 1;
        else if (!we) begin
            exp_ar.push_back({addr, len});
            for (int i = 0; i <= int'(len); i++) begin
                d  = base + i * 32'h0101_0101;
                rr = ($urandom_range(0, 99) < resp_err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
                rd_plan.push_back({d, rr, i == int'(len)});
                exp_rd.push_back(d);
`ifdef AXI_MASTER_RESP_CHECK_EN
                if (rr != 2'b00) exp_err = 1;
`endif
            end
        end else begin
            exp_aw.push_back({addr, len});
            for (int i = 0; i <= int'(len); i++) begin
                wd[i]  = base ^ (i * 32'h1357_9BDF);
                wsb[i] = 4'($urandom_range(1, 15));
                exp_w.push_back({wd[i], wsb[i], i == int'(len)});
            end
            b_resp_plan = bresp;
`ifdef AXI_MASTER_RESP_CHECK_EN
            if (bresp != 2'b00) exp_err = 1;
`endif
        end
        exp_done.push_back(exp_err);

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_len   = len;
        cpu_wdata = (we && len < 8'd4) ? wd[0] : '0;
        cpu_wstrb = (we && len < 8'd4) ? wsb[0] : '0;
        @(posedge ACLK); #1;
        cpu_req = 1'b0;
        idx = 0;
        wn_cnt = 0;
        dn = 0;
        for (int g = 0; g < 400 && !dn; g++) begin
            @(negedge ACLK);
            if (g == 0) begin
                if (len >= 8'd4)
                    check({cpu_done, cpu_err, bus.ARVALID_M, bus.AWVALID_M} == 4'b1100,
                          "oversize_cycle1", {cpu_done, cpu_err, bus.ARVALID_M, bus.AWVALID_M}, 4'b1100);
                else if (we) check(bus.AWVALID_M, "awvalid_cycle1", bus.AWVALID_M, 1);
                else check(bus.ARVALID_M, "arvalid_cycle1", bus.ARVALID_M, 1);
            end
            wn = cpu_wnext;
            dn = cpu_done;
            if (wn) wn_cnt++;
            if (!dn) begin
                @(posedge ACLK); #1;
                if (wn && idx < int'(len)) begin
                    idx++;
                    cpu_wdata = wd[idx];
                    cpu_wstrb = wsb[idx];
                end
            end
        end
        check(dn, "done_timeout", dn, 1);
        if (we && len < 8'd4) check(wn_cnt == int'(len) + 1, "wnext_count", wn_cnt, int'(len) + 1);
        @(posedge ACLK); #1;
    endtask

    // ---------------- Main sequence ----------------
    initial begin : main
        bit          we;
        logic [7:0]  len;
        logic [1:0]  br;
        ARESET = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_len = '0; cpu_wdata = '0; cpu_wstrb = '0;
        ar_delay = 0; aw_delay = 0; w_ready_pct = 100; w_stall_beat = -1;
        r_pct = 100; r_toggle = 0; b_resp_plan = 2'b00;
        repeat (3) @(posedge ACLK);
        #1;
        check({bus.ARVALID_M, bus.AWVALID_M, bus.WVALID_M, bus.RREADY_M, bus.BREADY_M,
               cpu_wnext, cpu_rvalid, cpu_busy, cpu_done, cpu_err} == 10'd0, "reset_outputs",
              {bus.ARVALID_M, bus.AWVALID_M, bus.WVALID_M, bus.RREADY_M, bus.BREADY_M,
               cpu_wnext, cpu_rvalid, cpu_busy, cpu_done, cpu_err}, 0);
        check({bus.ARADDR_M, cpu_rdata} == 64'd0, "reset_data", {bus.ARADDR_M, cpu_rdata}, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check(dbg_state == ST_IDLE && !cpu_busy, "idle_after_reset", {dbg_state, cpu_busy}, 0);
        @(posedge ACLK); #1;

        // Single read with ARREADY held off for two cycles.
        ar_delay = 2;
        do_req(0, 32'h0000_0010, 8'd0, 32'hDEAD_BEEF, 0, 2'b00);
        ar_delay = 0;

        // Four-beat read with RVALID on alternate cycles.
        r_toggle = 1;
        do_req(0, 32'h0000_0100, 8'd3, $urandom, 0, 2'b00);
        r_toggle = 0;

        // Four-beat write with WREADY low for three cycles on the second beat.
        w_stall_beat = 1;
        do_req(1, 32'h0000_0200, 8'd3, $urandom, 0, 2'b00);
        w_stall_beat = -1;

        // Oversize requests are rejected without bus traffic.
        do_req(0, 32'h0000_0300, 8'd5, $urandom, 0, 2'b00);
        do_req(1, 32'h0000_0304, 8'd4, $urandom, 0, 2'b00);

        // Write answered with SLVERR.
        do_req(1, 32'h0000_0400, 8'd1, $urandom, 0, RESP_SLVERR);

        // Reset while the bridge is in W with the slave refusing data.
        w_ready_pct = 0;
        exp_aw.push_back({32'h0000_0600, 8'd3});
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0600; cpu_len = 8'd3;
        cpu_wdata = 32'hA5A5_0001; cpu_wstrb = 4'hF;
        @(posedge ACLK); #1;
        cpu_req = 0;
        for (int g = 0; g < 50 && !bus.WVALID_M; g++) @(negedge ACLK);
        check(bus.WVALID_M, "reach_w_state", bus.WVALID_M, 1);
        #2 ARESET = 1'b1;
        #1;
        check({bus.WVALID_M, bus.AWVALID_M, bus.ARVALID_M, bus.BREADY_M, bus.RREADY_M, cpu_busy, cpu_done}
              == 7'd0, "reset_drops_valids",
              {bus.WVALID_M, bus.AWVALID_M, bus.ARVALID_M, bus.BREADY_M, bus.RREADY_M, cpu_busy, cpu_done}, 0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        w_ready_pct = 100;
        @(negedge ACLK);
        check(dbg_state == ST_IDLE && !cpu_busy, "idle_after_mid_reset", {dbg_state, cpu_busy}, 0);
        @(posedge ACLK); #1;
        do_req(0, 32'h0000_0500, 8'd2, $urandom, 0, 2'b00);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            br  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ar_delay    = $urandom_range(0, 3);
            aw_delay    = $urandom_range(0, 3);
            r_pct       = $urandom_range(40, 100);
            w_ready_pct = $urandom_range(40, 100);
            do_req(we, $urandom & 32'hFFFF_FFFC, len, $urandom, 15, br);
        end

        repeat (4) @(negedge ACLK);
        check(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rd.size() + exp_done.size() == 0,
              "queues_drained", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rd.size() + exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
